flit_injector: RTL and testbench

Injection-side front end of the bufferless router. It accepts locally generated flits from the processing element through a valid/ready handshake and buffers them in a small FIFO. It writes the age (injection timestamp) field and valid bit that the router's age-based permutation and arbitration logic later reads. Buffered flits are presented to the router one at a time and dequeue only in cycles where the router reports a free input slot.

---
 rtl/flit_injector.sv | 126 ++++++++++++
 tb/tb_flit_injector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/flit_injector.sv
// flit_injector: injection-side front end of the bufferless router.
// Accepts PE flits over a valid/ready handshake and buffers them in a small
// first-word-fall-through FIFO. Each flit is stamped with the current cycle
// count and its valid bit on entry. The head flit leaves only when the router
// reports a free input slot.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   pe_valid     PE offers a flit
//   pe_flit      flit from PE (timestamp and valid fields are overwritten)
//   pe_ready     FIFO has room (registered occupancy only)
//   slot_free    router has an empty input port this cycle
//   inj_valid    a stamped head flit is presented
//   inj_flit     stamped head flit, zero when inj_valid=0
//   occupancy    current FIFO entry count
//   time_now     free-running cycle counter
//   starve       head flit has waited STARVE_LIMIT cycles without leaving
module flit_injector #(
    parameter int unsigned FLIT_W       = 64,
    parameter int unsigned TIME_W       = 8,
    parameter int unsigned TIME_LSB     = 48,
    parameter int unsigned VALID_POS    = 63,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pe_valid,
    input  logic [FLIT_W-1:0]        pe_flit,
    output logic                     pe_ready,
    input  logic                     slot_free,
    output logic                     inj_valid,
    output logic [FLIT_W-1:0]        inj_flit,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [TIME_W-1:0]        time_now,
    output logic                     starve
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT) + 1;

    localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_LIMIT);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ_q;
    logic [TIME_W-1:0] time_q;
    logic [SCNT_W-1:0] scnt_q;

    logic [FLIT_W-1:0] stamped_c;
    logic              empty_c;
    logic              enq_c;
    logic              deq_c;

    // Handshake and pop conditions, all from registered occupancy.
    assign empty_c  = (occ_q == '0);
    assign pe_ready = (occ_q < OCC_FULL);
    assign enq_c    = pe_valid && pe_ready;
    assign deq_c    = !empty_c && slot_free;

    // Head presentation; suppressed while reset is held so nothing leaves in that cycle.
    assign inj_valid = !empty_c && !reset;
    assign inj_flit  = inj_valid ? mem[rd_ptr] : '0;
    assign occupancy = occ_q;
    assign time_now  = time_q;
    assign starve    = (scnt_q == SCNT_MAX) && !reset;

    // Overwrite the age field and valid bit of the incoming flit.
    always_comb begin
        stamped_c                       = pe_flit;
        stamped_c[TIME_LSB +: TIME_W]   = time_q;
        stamped_c[VALID_POS]            = 1'b1;
    end

    // Free-running injection timestamp, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            time_q <= '0;
        end else begin
            time_q <= time_q + TIME_W'(1);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && enq_c) begin
            mem[wr_ptr] <= stamped_c;
        end
    end

    // Pointers wrap modulo DEPTH by width; occupancy tracks enq/deq balance.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (enq_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Head wait counter: cleared on pop or when empty, saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            scnt_q <= '0;
        end else if (empty_c || deq_c) begin
            scnt_q <= '0;
        end else if (!slot_free && (scnt_q != SCNT_MAX)) begin
            scnt_q <= scnt_q + SCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_flit_injector.sv
module tb_flit_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        pe_valid;
    logic [63:0] pe_flit;
    logic        pe_ready;
    logic        slot_free;
    logic        inj_valid;
    logic [63:0] inj_flit;
    logic [2:0]  occupancy;
    logic [7:0]  time_now;
    logic        starve;

    flit_injector #(
        .FLIT_W(64), .TIME_W(8), .TIME_LSB(48), .VALID_POS(63),
        .DEPTH(4), .STARVE_LIMIT(16)
    ) dut (
        .clk(clk), .reset(reset), .pe_valid(pe_valid), .pe_flit(pe_flit),
        .pe_ready(pe_ready), .slot_free(slot_free), .inj_valid(inj_valid),
        .inj_flit(inj_flit), .occupancy(occupancy), .time_now(time_now),
        .starve(starve)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          m_occ;
    logic [7:0]  m_time;
    int          m_sc;

    function automatic logic [63:0] stamp(input logic [63:0] f, input logic [7:0] t);
        logic [63:0] r;
        r         = f;
        r[55:48]  = t;
        r[63]     = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_occ  = 0;
        m_time = 8'd0;
        m_sc   = 0;
    endtask

    // Compare all outputs against the model, advance the model, then clock.
    task automatic cycle();
        logic [63:0] head;
        bit          enq;
        bit          deq;
        head = (m_occ != 0) ? exp_q[0] : 64'h0;
        chk("time_now",  64'(time_now),  64'(m_time));
        chk("occupancy", 64'(occupancy), 64'(m_occ));
        chk("pe_ready",  64'(pe_ready),  64'(m_occ < 4));
        chk("inj_valid", 64'(inj_valid), 64'(m_occ != 0));
        chk("inj_flit",  inj_flit,       head);
        chk("starve",    64'(starve),    64'(m_sc == 16));
        enq = pe_valid && (m_occ < 4);
        deq = (m_occ != 0) && slot_free;
        if (m_occ == 0 || deq) m_sc = 0;
        else if (!slot_free && m_sc < 16) m_sc++;
        if (deq) void'(exp_q.pop_front());
        if (enq) exp_q.push_back(stamp(pe_flit, m_time));
        m_occ  = m_occ + int'(enq) - int'(deq);
        m_time = m_time + 8'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        pe_valid  = 1'b0;
        pe_flit   = 64'h0;
        slot_free = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Reset state
        chk("rst_time", 64'(time_now), 64'd0);
        chk("rst_ready", 64'(pe_ready), 64'd1);
        chk("rst_inj_flit", inj_flit, 64'h0);

        // Single flit accepted at cycle 3, presented in cycle 4, leaves at edge 4
        slot_free = 1'b1;
        repeat (3) cycle();
        pe_valid = 1'b1;
        pe_flit  = 64'h0123_4567_89AB_CDEF;
        cycle();
        pe_valid = 1'b0;
        chk("t1_valid", 64'(inj_valid), 64'd1);
        chk("t1_flit", inj_flit, 64'h8103_4567_89AB_CDEF);
        cycle();
        chk("t1_drained", 64'(occupancy), 64'd0);

        // Five back-to-back offers into a stalled FIFO: four fit, fifth held
        slot_free = 1'b0;
        pe_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pe_flit = {$urandom, $urandom};
            cycle();
        end
        chk("t2_full_ready", 64'(pe_ready), 64'd0);
        chk("t2_full_occ", 64'(occupancy), 64'd4);
        slot_free = 1'b1;
        cycle();
        slot_free = 1'b0;
        chk("t2_ready_back", 64'(pe_ready), 64'd1);
        chk("t2_occ_after_pop", 64'(occupancy), 64'd3);
        cycle();
        chk("t2_fifth_in", 64'(occupancy), 64'd4);

        // Full FIFO with continuous offer and continuous drain
        slot_free = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pe_flit = {$urandom, $urandom};
            cycle();
        end
        pe_valid = 1'b0;
        repeat (6) cycle();
        chk("t3_empty", 64'(occupancy), 64'd0);

        // Starvation: head stalls for 20 cycles
        slot_free = 1'b0;
        pe_valid  = 1'b1;
        pe_flit   = {$urandom, $urandom};
        cycle();
        pe_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("t4_starve_ramp", 64'(starve), 64'(k >= 16));
            cycle();
        end
        slot_free = 1'b1;
        cycle();
        slot_free = 1'b0;
        chk("t4_starve_clear", 64'(starve), 64'd0);

        // Timestamp wrap: enqueue at 255 and at 0
        for (int n = 0; n < 300 && m_time != 8'd255; n++) cycle();
        chk("t5_at_255", 64'(time_now), 64'd255);
        pe_valid = 1'b1;
        pe_flit  = {$urandom, $urandom};
        cycle();
        chk("t5_wrapped", 64'(time_now), 64'd0);
        pe_flit = {$urandom, $urandom};
        cycle();
        pe_valid = 1'b0;
        chk("t5_stamp_255", 64'(inj_flit[55:48]), 64'd255);
        slot_free = 1'b1;
        cycle();
        slot_free = 1'b0;
        chk("t5_stamp_0", 64'(inj_flit[55:48]), 64'd0);
        slot_free = 1'b1;
        cycle();

        // Reset with three flits queued: contents discarded
        slot_free = 1'b0;
        pe_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pe_flit = {$urandom, $urandom};
            cycle();
        end
        pe_valid = 1'b0;
        chk("t6_queued", 64'(occupancy), 64'd3);
        reset     = 1'b1;
        slot_free = 1'b1;
        #1;
        chk("t6_no_inj_in_reset", 64'(inj_valid), 64'd0);
        chk("t6_no_starve_in_reset", 64'(starve), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("t6_occ", 64'(occupancy), 64'd0);
        chk("t6_valid", 64'(inj_valid), 64'd0);
        chk("t6_flit", inj_flit, 64'h0);
        chk("t6_time", 64'(time_now), 64'd0);
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
